spike_event_buffer: RTL and testbench

SPIKE_EVENT_BUFFER -- requirements
Module: spike_event_buffer

---
 rtl/spike_event_buffer.sv | 124 ++++++++++++
 tb/tb_spike_event_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_buffer.sv
// Spike event buffer: detects classifier window boundaries, timestamps
// accepted spikes, applies a refractory period and queues events in a FIFO.
module spike_event_buffer #(
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16,
  parameter int REFRACT    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [4:0]                    cntr,
  input  logic [1:0]                    class_in,
  input  logic                          ev_ready,
  input  logic                          ov_clr,
  output logic                          ev_valid,
  output logic [1:0]                    ev_class,
  output logic [TS_WIDTH-1:0]           ev_ts,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Keep the countdown at least one bit wide so REFRACT == 0 still elaborates.
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_REFRACT} state_t;

  state_t                state;
  logic [RW-1:0]         refr_cnt;
  logic [4:0]            cntr_d;
  logic [TS_WIDTH-1:0]   ts_cnt;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [1:0]            mem_class [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]   mem_ts    [FIFO_DEPTH];

  logic strobe;
  logic push_req;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign strobe   = (cntr == 5'd0) && (cntr_d == 5'd31);
  assign full     = (fill == FULL_LVL);
  assign ev_valid = (fill != '0);
  assign pop      = ev_valid && ev_ready;
  assign push_req = strobe && en && (class_in != 2'b00) && (state == ST_IDLE);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign ev_class = ev_valid ? mem_class[rd_ptr] : '0;
  assign ev_ts    = ev_valid ? mem_ts[rd_ptr]    : '0;

  // Window boundary tracking and free-running window timestamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cntr_d <= '0;
      ts_cnt <= '0;
    end else begin
      cntr_d <= cntr;
      if (strobe) ts_cnt <= ts_cnt + 1'b1;
    end
  end

  // Refractory FSM: an accepted spike (even if dropped) blocks the next REFRACT strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      refr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (push_req && (REFRACT > 0)) begin
            state    <= ST_REFRACT;
            refr_cnt <= RW'(REFRACT);
          end
        end
        ST_REFRACT: begin
          if (strobe) begin
            refr_cnt <= refr_cnt - 1'b1;
            if (refr_cnt == RW'(1)) state <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          refr_cnt <= '0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fill <= fill + 1'b1;
      else if (!push && pop) fill <= fill - 1'b1;
    end
  end

  // Event storage write.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_class[wr_ptr] <= class_in;
      mem_ts[wr_ptr]    <= ts_cnt;
    end
  end

  // Sticky overflow flag; a drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ov_clr)  overflow <= 1'b0;
  end

endmodule

// File: tb/tb_spike_event_buffer.sv
// Self-checking bench for spike_event_buffer: reference model + scoreboard.
module tb_spike_event_buffer;

  localparam int DEPTH = 8;
  localparam int TSW   = 4;
  localparam int REF   = 2;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic [4:0]            cntr;
  logic [1:0]            class_in;
  logic                  ev_ready;
  logic                  ov_clr;
  logic                  ev_valid;
  logic [1:0]            ev_class;
  logic [TSW-1:0]        ev_ts;
  logic                  overflow;
  logic [$clog2(DEPTH):0] fill;

  spike_event_buffer #(
    .FIFO_DEPTH (DEPTH),
    .TS_WIDTH   (TSW),
    .REFRACT    (REF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cntr     (cntr),
    .class_in (class_in),
    .ev_ready (ev_ready),
    .ov_clr   (ov_clr),
    .ev_valid (ev_valid),
    .ev_class (ev_class),
    .ev_ts    (ev_ts),
    .overflow (overflow),
    .fill     (fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]     c;
    logic [TSW-1:0] t;
  } ev_t;

  ev_t  exp_q[$];
  int   m_fill;
  bit   m_ovf;
  logic [4:0] m_prev;
  int   sidx;
  int   last_acc;
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // Reference model: window index counting, refractory gap, FIFO occupancy.
  always @(posedge clk) begin
    if (!rst) begin
      m_fill = 0; m_ovf = 0; m_prev = 5'd0; sidx = 0; last_acc = -100;
      exp_q.delete();
    end else begin
      bit is_strobe;
      bit popping;
      bit dropped;
      ev_t e;
      is_strobe = (cntr == 5'd0) && (m_prev == 5'd31);
      popping   = ev_ready && (m_fill > 0);
      dropped   = 0;
      if (popping) m_fill--;
      if (is_strobe) begin
        if (en && class_in != 2'b00 && (sidx - last_acc) > REF) begin
          last_acc = sidx;
          if (m_fill == DEPTH) dropped = 1;
          else begin
            e.c = class_in;
            e.t = TSW'(sidx);
            exp_q.push_back(e);
            m_fill++;
          end
        end
        sidx++;
      end
      if (dropped) m_ovf = 1;
      else if (ov_clr) m_ovf = 0;
      m_prev = cntr;
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_fill", fill, 0);
      chk("rst_valid", ev_valid, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_head", {ev_class, ev_ts}, 0);
    end else begin
      chk("fill", fill, m_fill);
      chk("ev_valid", ev_valid, (m_fill != 0));
      chk("overflow", overflow, m_ovf);
      if (ev_valid) begin
        if (exp_q.size() == 0) begin
          chk("head_unexpected", 1, 0);
        end else if (ev_ready) begin
          ev_t e;
          e = exp_q.pop_front();
          chk("pop_class", ev_class, e.c);
          chk("pop_ts", ev_ts, e.t);
        end else begin
          chk("hold_class", ev_class, exp_q[0].c);
          chk("hold_ts", ev_ts, exp_q[0].t);
        end
      end
    end
  end

  // One classifier window: cntr 0..31; class/en/ready-at-strobe set with cntr=0.
  // rmode: 0 ready low, 1 ready high, 2 random. cmode: 0 none, 1 clear at strobe, 2 clear mid-window.
  task automatic window(input logic [1:0] cls, input logic e, input logic rs,
                        input int rmode, input int cmode);
    for (int unsigned i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      cntr   = cntr + 5'd1;
      ov_clr = 1'b0;
      if (i == 0) begin
        class_in = cls;
        en       = e;
        ev_ready = rs;
        ov_clr   = (cmode == 1);
      end else begin
        ev_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
        if (i == 5 && cmode == 2) ov_clr = 1'b1;
      end
    end
  endtask

  // Reset with cntr parked at 0, then sweep up to 31 so the next window strobes.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; cntr = 5'd0; ev_ready = 1'b0; ov_clr = 1'b0; en = 1'b1; class_in = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      cntr = 5'(i);
    end
  endtask

  task automatic drain();
    repeat (3) window(2'b00, 1'b1, 1'b1, 1, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cntr = 5'd0; class_in = 2'b00; ev_ready = 1'b0; ov_clr = 1'b0;
    #2 rst = 1'b0;
    do_reset();

    // Single spike at window 3.
    for (int w = 0; w < 6; w++) window((w == 3) ? 2'b01 : 2'b00, 1'b1, 1'b0, 0, 0);
    drain();

    // Four consecutive spike windows: refractory keeps only first and fourth.
    for (int w = 0; w < 4; w++) window(2'b10, 1'b1, 1'b0, 0, 0);
    window(2'b00, 1'b1, 1'b0, 0, 0);
    drain();

    // Nine spaced spikes with no consumer: fill saturates, ninth dropped.
    for (int k = 0; k < 9; k++) begin
      window(2'b11, 1'b1, 1'b0, 0, 0);
      window(2'b00, 1'b1, 1'b0, 0, 0);
      window(2'b00, 1'b1, 1'b0, 0, 0);
    end
    window(2'b00, 1'b1, 1'b0, 0, 2);
    // Full FIFO with pop on the strobe edge: accepted, no overflow.
    window(2'b01, 1'b1, 1'b1, 0, 0);
    window(2'b00, 1'b1, 1'b0, 0, 0);
    window(2'b00, 1'b1, 1'b0, 0, 0);
    // Full FIFO drop coinciding with clear: overflow must stay set.
    window(2'b10, 1'b1, 1'b0, 0, 1);
    window(2'b00, 1'b1, 1'b0, 0, 2);
    drain();
    drain();

    // Three events queued, then reset while refractory is active.
    window(2'b01, 1'b1, 1'b0, 0, 0);
    window(2'b00, 1'b1, 1'b0, 0, 0);
    window(2'b00, 1'b1, 1'b0, 0, 0);
    window(2'b10, 1'b1, 1'b0, 0, 0);
    window(2'b00, 1'b1, 1'b0, 0, 0);
    window(2'b00, 1'b1, 1'b0, 0, 0);
    window(2'b11, 1'b1, 1'b0, 0, 0);
    do_reset();
    window(2'b01, 1'b1, 1'b0, 0, 0);
    drain();

    // Randomized traffic, including timestamp wrap and en toggling.
    for (int w = 0; w < 160; w++) begin
      window(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 2, ($urandom_range(0, 9) == 0) ? 2 : 0);
    end
    drain();
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
